// File: rtl/kb_pkg.sv
// Shared types and helpers for the keyboard-to-UART transmit bridge.
package kb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_BYTE = 2'd2
  } kb_state_e;

  localparam logic [7:0] KB_SYNC_BYTE = 8'hA5;

  // Number of UART bytes needed to carry a pw-bit payload.
  function automatic int kb_nbytes(input int pw);
    return (pw + 7) / 8;
  endfunction

endpackage

// File: rtl/kb_tx_bridge_if.sv
// Keycode ingress, UART byte egress and drop-status bundle of the transmit bridge.
interface kb_tx_bridge_if #(
  parameter int KEY_W = 9,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  logic                     i_key_valid;
  logic [KEY_W-1:0]         i_keycode;
  logic [7:0]               o_tx_data;
  logic                     o_tx_valid;
  logic                     i_tx_ready;
  logic [$clog2(DEPTH):0]   o_fifo_level;
  logic                     o_overflow;
  logic                     i_clr_overflow;
  logic [CNT_W-1:0]         o_drop_count;

  modport slave (
    input  i_key_valid, i_keycode, i_tx_ready, i_clr_overflow,
    output o_tx_data, o_tx_valid, o_fifo_level, o_overflow, o_drop_count
  );

  modport master (
    output i_key_valid, i_keycode, i_tx_ready, i_clr_overflow,
    input  o_tx_data, o_tx_valid, o_fifo_level, o_overflow, o_drop_count
  );
endinterface

// File: rtl/kb_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module kb_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign o_full  = (cnt == FULL_CNT);
  assign o_empty = (cnt == '0);
  assign o_level = cnt;
  assign o_rdata = mem[rptr];
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr] <= i_wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/kb_tx_bridge.sv
// Queues PS/2 keycodes and serialises each into MSB-first UART bytes,
// optionally prefixed with a sync byte; full-FIFO drops are flagged and counted.
module kb_tx_bridge
  import kb_pkg::*;
#(
  parameter int         KEY_W     = 9,
  parameter int         LSB_DROP  = 1,
  parameter int         DEPTH     = 8,
  parameter int         SYNC_EN   = 0,
  parameter logic [7:0] SYNC_BYTE = KB_SYNC_BYTE,
  parameter int         CNT_W     = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  kb_tx_bridge_if.slave bus
);
  localparam int PW = KEY_W - LSB_DROP;
  localparam int NB = kb_nbytes(PW);
  localparam int SW = NB * 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  kb_state_e        state, state_n;
  logic [SW-1:0]    shreg, shreg_n, head_ext;
  logic [IW-1:0]    idx, idx_n;
  logic             tx_valid, tx_valid_n;
  logic [7:0]       tx_data, tx_data_n;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [PW-1:0]    fifo_rdata;
  logic [LW-1:0]    fifo_level;
  logic             ovf;
  logic [CNT_W-1:0] drop_cnt;

  assign fifo_push = bus.i_key_valid && (!fifo_full || fifo_pop);
  assign drop      = bus.i_key_valid && fifo_full && !fifo_pop;
  assign head_ext  = SW'(fifo_rdata);

  kb_sync_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_wdata (bus.i_keycode[KEY_W-1:LSB_DROP]),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      idx      <= idx_n;
      tx_valid <= tx_valid_n;
      tx_data  <= tx_data_n;
    end
  end

  // Output byte is always the top byte of the shift register, so each
  // accepted payload byte shifts the frame left by one byte.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    idx_n      = idx;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    fifo_pop   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_n    = head_ext;
          idx_n      = IW'(NB - 1);
          tx_valid_n = 1'b1;
          if (SYNC_EN != 0) begin
            state_n   = ST_SYNC;
            tx_data_n = SYNC_BYTE;
          end else begin
            state_n   = ST_BYTE;
            tx_data_n = head_ext[SW-1 -: 8];
          end
        end
      end
      ST_SYNC: begin
        if (bus.i_tx_ready) begin
          state_n   = ST_BYTE;
          tx_data_n = shreg[SW-1 -: 8];
        end
      end
      ST_BYTE: begin
        if (bus.i_tx_ready) begin
          if (idx == '0) begin
            state_n    = ST_IDLE;
            tx_valid_n = 1'b0;
          end else begin
            idx_n     = idx - 1'b1;
            shreg_n   = shreg << 8;
            tx_data_n = shreg_n[SW-1 -: 8];
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Clear wins over a same-cycle drop; that drop is simply not recorded.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (bus.i_clr_overflow) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign bus.o_tx_data    = tx_data;
  assign bus.o_tx_valid   = tx_valid;
  assign bus.o_fifo_level = fifo_level;
  assign bus.o_overflow   = ovf;
  assign bus.o_drop_count = drop_cnt;

endmodule

// File: tb/tb_kb_tx_bridge.sv
// Directed bench: default 1-byte bridge, 3-byte sync-framed bridge, 2-bit drop counter.
module tb_kb_tx_bridge;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  kb_tx_bridge_if #(.KEY_W(9),  .DEPTH(8), .CNT_W(8)) b0 ();
  kb_tx_bridge_if #(.KEY_W(17), .DEPTH(8), .CNT_W(8)) b1 ();
  kb_tx_bridge_if #(.KEY_W(9),  .DEPTH(8), .CNT_W(2)) b2 ();

  kb_tx_bridge #(.KEY_W(9), .LSB_DROP(1), .DEPTH(8), .SYNC_EN(0), .SYNC_BYTE(8'hA5), .CNT_W(8))
    dut0 (.i_clk(clk), .i_rst(rst), .bus(b0));
  kb_tx_bridge #(.KEY_W(17), .LSB_DROP(0), .DEPTH(8), .SYNC_EN(1), .SYNC_BYTE(8'hA5), .CNT_W(8))
    dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));
  kb_tx_bridge #(.KEY_W(9), .LSB_DROP(1), .DEPTH(8), .SYNC_EN(0), .SYNC_BYTE(8'hA5), .CNT_W(2))
    dut2 (.i_clk(clk), .i_rst(rst), .bus(b2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept bytes from dut0 with ready held high until n bytes or budget expiry.
  task automatic drain0(input int n);
    got.delete();
    b0.i_tx_ready = 1'b1;
    for (int c = 0; c < 200 && got.size() < n; c++) begin
      if (b0.o_tx_valid) got.push_back(b0.o_tx_data);
      step();
    end
    b0.i_tx_ready = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++; if (b0.o_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", b0.o_tx_valid); end
    checks++; if (b0.o_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", b0.o_tx_data); end
    checks++; if (b0.o_fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d exp 0", b0.o_fifo_level); end
    checks++; if (b0.o_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b exp 0", b0.o_overflow); end
    checks++; if (b0.o_drop_count !== 8'd0) begin errors++; $display("FAIL rst_drops: got %0d exp 0", b0.o_drop_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int highs;
    b0.i_tx_ready  = 1'b1;
    b0.i_key_valid = 1'b1;
    b0.i_keycode   = 9'h1C3;
    step();
    b0.i_key_valid = 1'b0;
    checks++; if (b0.o_tx_valid !== 1'b0) begin errors++; $display("FAIL single_n1_valid: got %b exp 0", b0.o_tx_valid); end
    checks++; if (b0.o_fifo_level !== 4'd1) begin errors++; $display("FAIL single_n1_level: got %0d exp 1", b0.o_fifo_level); end
    step();
    checks++; if (b0.o_tx_valid !== 1'b1) begin errors++; $display("FAIL single_n2_valid: got %b exp 1", b0.o_tx_valid); end
    checks++; if (b0.o_tx_data !== 8'hE1) begin errors++; $display("FAIL single_data: got %h exp e1", b0.o_tx_data); end
    highs = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (b0.o_tx_valid) highs++;
    end
    checks++; if (highs !== 0) begin errors++; $display("FAIL single_one_cycle: got %0d extra valid cycles exp 0", highs); end
    b0.i_tx_ready = 1'b0;
  endtask

  // Key 0 is popped into the serialiser, keys 1..8 fill the FIFO, keys 9..10 drop.
  task automatic test_overflow();
    b0.i_tx_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      b0.i_key_valid = 1'b1;
      b0.i_keycode   = {8'(8'h10 + i), 1'b1};
      step();
    end
    b0.i_key_valid = 1'b0;
    checks++; if (b0.o_fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d exp 8", b0.o_fifo_level); end
    checks++; if (b0.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", b0.o_overflow); end
    checks++; if (b0.o_drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drops: got %0d exp 2", b0.o_drop_count); end
    checks++; if (b0.o_tx_data !== 8'h10) begin errors++; $display("FAIL ovf_stall_data: got %h exp 10", b0.o_tx_data); end
    drain0(9);
    checks++; if (got.size() !== 9) begin errors++; $display("FAIL ovf_count: got %0d exp 9", got.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL ovf_byte%0d: got %h exp %h", i, got[i], 8'(8'h10 + i)); end
      end
    end
    checks++; if (b0.o_fifo_level !== 4'd0) begin errors++; $display("FAIL ovf_drained: got %0d exp 0", b0.o_fifo_level); end
    b0.i_clr_overflow = 1'b1;
    step();
    b0.i_clr_overflow = 1'b0;
    checks++; if (b0.o_overflow !== 1'b0 || b0.o_drop_count !== 8'd0) begin errors++; $display("FAIL ovf_clear: got %b/%0d exp 0/0", b0.o_overflow, b0.o_drop_count); end
  endtask

  task automatic test_full_pop();
    b0.i_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b0.i_key_valid = 1'b1;
      b0.i_keycode   = {8'(8'h40 + i), 1'b0};
      step();
    end
    b0.i_key_valid = 1'b0;
    checks++; if (b0.o_fifo_level !== 4'd8) begin errors++; $display("FAIL fp_full: got %0d exp 8", b0.o_fifo_level); end
    b0.i_tx_ready = 1'b1;
    step();
    b0.i_tx_ready  = 1'b0;
    b0.i_key_valid = 1'b1;
    b0.i_keycode   = {8'h5A, 1'b0};
    checks++; if (b0.o_tx_valid !== 1'b0) begin errors++; $display("FAIL fp_idle: got %b exp 0", b0.o_tx_valid); end
    step();
    b0.i_key_valid = 1'b0;
    checks++; if (b0.o_fifo_level !== 4'd8) begin errors++; $display("FAIL fp_level: got %0d exp 8", b0.o_fifo_level); end
    checks++; if (b0.o_drop_count !== 8'd0 || b0.o_overflow !== 1'b0) begin errors++; $display("FAIL fp_nodrop: got %b/%0d exp 0/0", b0.o_overflow, b0.o_drop_count); end
    drain0(9);
    checks++; if (got.size() !== 9) begin errors++; $display("FAIL fp_count: got %0d exp 9", got.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < got.size()) begin
        logic [7:0] e;
        e = (i == 8) ? 8'h5A : 8'(8'h41 + i);
        checks++;
        if (got[i] !== e) begin errors++; $display("FAIL fp_byte%0d: got %h exp %h", i, got[i], e); end
      end
    end
  endtask

  task automatic test_sync_frame();
    logic [7:0] exp_s [4];
    logic       prev_stall;
    logic [7:0] prev_data;
    exp_s = '{8'hA5, 8'h01, 8'hAB, 8'hCD};
    got.delete();
    b1.i_key_valid = 1'b1;
    b1.i_keycode   = 17'h1ABCD;
    step();
    b1.i_key_valid = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 300 && got.size() < 4; c++) begin
      if (prev_stall) begin
        checks++;
        if (b1.o_tx_valid !== 1'b1 || b1.o_tx_data !== prev_data) begin
          errors++; $display("FAIL sync_stable: got %b/%h exp 1/%h", b1.o_tx_valid, b1.o_tx_data, prev_data);
        end
      end
      b1.i_tx_ready = 1'($urandom_range(0, 1));
      if (b1.o_tx_valid && b1.i_tx_ready) got.push_back(b1.o_tx_data);
      prev_stall = b1.o_tx_valid && !b1.i_tx_ready;
      prev_data  = b1.o_tx_data;
      step();
    end
    b1.i_tx_ready = 1'b0;
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL sync_count: got %0d exp 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_s[i]) begin errors++; $display("FAIL sync_byte%0d: got %h exp %h", i, got[i], exp_s[i]); end
      end
    end
    step();
    checks++; if (b1.o_tx_valid !== 1'b0) begin errors++; $display("FAIL sync_end: got %b exp 0", b1.o_tx_valid); end
  endtask

  task automatic test_saturate();
    b2.i_tx_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      b2.i_key_valid = 1'b1;
      b2.i_keycode   = 9'(i * 2);
      step();
    end
    b2.i_key_valid = 1'b0;
    checks++; if (b2.o_drop_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d exp 3", b2.o_drop_count); end
    checks++; if (b2.o_overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b exp 1", b2.o_overflow); end
    b2.i_key_valid    = 1'b1;
    b2.i_clr_overflow = 1'b1;
    step();
    b2.i_clr_overflow = 1'b0;
    checks++; if (b2.o_drop_count !== 2'd0 || b2.o_overflow !== 1'b0) begin errors++; $display("FAIL clr_vs_drop: got %b/%0d exp 0/0", b2.o_overflow, b2.o_drop_count); end
    step();
    b2.i_key_valid = 1'b0;
    checks++; if (b2.o_drop_count !== 2'd1 || b2.o_overflow !== 1'b1) begin errors++; $display("FAIL drop_after_clr: got %b/%0d exp 1/1", b2.o_overflow, b2.o_drop_count); end
  endtask

  task automatic test_reset_mid();
    int waited;
    b1.i_tx_ready  = 1'b0;
    b1.i_key_valid = 1'b1;
    b1.i_keycode   = 17'h00012;
    step();
    b1.i_keycode   = 17'h00034;
    step();
    b1.i_key_valid = 1'b0;
    checks++; if (b1.o_tx_valid !== 1'b1 || b1.o_tx_data !== 8'hA5) begin errors++; $display("FAIL mid_sync: got %b/%h exp 1/a5", b1.o_tx_valid, b1.o_tx_data); end
    b1.i_tx_ready = 1'b1;
    step();
    b1.i_tx_ready = 1'b0;
    checks++; if (b1.o_tx_data !== 8'h00 || b1.o_fifo_level !== 4'd1) begin errors++; $display("FAIL mid_byte: got %h/%0d exp 00/1", b1.o_tx_data, b1.o_fifo_level); end
    rst = 1'b1;
    #1;
    checks++; if (b1.o_tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b exp 0", b1.o_tx_valid); end
    checks++; if (b1.o_fifo_level !== 4'd0) begin errors++; $display("FAIL mid_rst_level: got %0d exp 0", b1.o_fifo_level); end
    step();
    rst = 1'b0;
    step();
    b1.i_key_valid = 1'b1;
    b1.i_keycode   = 17'h1ABCD;
    step();
    b1.i_key_valid = 1'b0;
    waited = 0;
    while (!b1.o_tx_valid && waited < 10) begin
      step();
      waited++;
    end
    checks++; if (b1.o_tx_valid !== 1'b1 || b1.o_tx_data !== 8'hA5) begin errors++; $display("FAIL mid_fresh: got %b/%h exp 1/a5", b1.o_tx_valid, b1.o_tx_data); end
    checks++; if (waited !== 1) begin errors++; $display("FAIL mid_latency: got %0d exp 1", waited); end
  endtask

  initial begin
    rst = 1'b1;
    b0.i_key_valid = 1'b0; b0.i_keycode = '0; b0.i_tx_ready = 1'b0; b0.i_clr_overflow = 1'b0;
    b1.i_key_valid = 1'b0; b1.i_keycode = '0; b1.i_tx_ready = 1'b0; b1.i_clr_overflow = 1'b0;
    b2.i_key_valid = 1'b0; b2.i_keycode = '0; b2.i_tx_ready = 1'b0; b2.i_clr_overflow = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_sync_frame();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
